random_csr_rsp: RTL and testbench

- Testbench responder model for the two FCSR request channels: enq_0 carries fcsr read-write requests, enq_1 carries fcsr read-set requests.
- Drives pseudo-random backpressure on both ready signals.
- Models outstanding fcsr writes with a bounded counter and a per-write retire timer, and blocks reads while writes are outstanding (read-after-write hazard).
- Checks valid/ready stability on both channels and keeps acceptance statistics for the bench.

---
 rtl/random_csr_rsp_pkg.sv | 19 +
 rtl/lfsr.sv | 12 +
 rtl/random_csr_rsp.sv | 123 ++++++++++++
 tb/tb_random_csr_rsp.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/random_csr_rsp_pkg.sv
// rtl/random_csr_rsp_pkg.sv - shared types and constants for the fcsr responder model
package random_csr_rsp_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  localparam int ERR_CH0 = 0;
  localparam int ERR_CH1 = 1;

  localparam int BP0_LO = 0;
  localparam int BP0_HI = 2;
  localparam int BP1_LO = 3;
  localparam int BP1_HI = 5;
  localparam int LAT_LO = 12;
  localparam int LAT_HI = 15;

endpackage

// File: rtl/lfsr.sv
// rtl/lfsr.sv - free-running 16-bit xnor lfsr used as the random source
module lfsr (
  input  logic        CLK,
  output logic [15:0] random
);

  // xnor feedback keeps the all-zero power-up state inside the sequence
  always_ff @(posedge CLK) begin
    random <= {random[14:0], ~(random[15] ^ random[14] ^ random[12] ^ random[3])};
  end

endmodule

// File: rtl/random_csr_rsp.sv
// rtl/random_csr_rsp.sv - fcsr rw/rs responder with backpressure, write retire model and protocol checks
module random_csr_rsp
  import random_csr_rsp_pkg::*;
#(
  parameter int         DEPTH   = 4,
  parameter int         CNT_W   = 32,
  parameter int         RAND_EN = 1,
  parameter logic [3:0] FIX_LAT = 4'd3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_enq_0_valid,
  input  logic             io_enq_0_bits_isa_fcsr_rw,
  output logic             io_enq_0_ready,
  input  logic             io_enq_1_valid,
  input  logic             io_enq_1_bits_isa_fcsr_rs,
  output logic             io_enq_1_ready,
  output logic [3:0]       wr_cnt,
  output logic [CNT_W-1:0] wr_acc_cnt,
  output logic [CNT_W-1:0] rd_acc_cnt,
  output logic [CNT_W-1:0] hazard_stall_cnt,
  output logic             proto_err,
  output logic [1:0]       proto_err_code
);

  localparam logic [3:0] DEPTH_W = 4'(DEPTH);

  logic [15:0] random;
  logic        unused_bits;
  state_t      state_q, state_d;
  logic [3:0]  timer_q, timer_d, reload, wr_cnt_d;
  logic        bp0_q, bp1_q, bp0_d, bp1_d;
  logic        fire0, fire1, inc, dec, rd_inc, hz_inc;
  logic        stall0_q, stall1_q, held0_q, held1_q, viol0, viol1;

  lfsr u_lfsr (
    .CLK    (clock),
    .random (random)
  );

  assign unused_bits = ^random[LAT_LO-1:BP1_HI+1];

  assign reload = (RAND_EN != 0) ? random[LAT_HI:LAT_LO] : FIX_LAT;
  assign bp0_d  = (RAND_EN != 0) ? (random[BP0_HI:BP0_LO] != 3'd0) : 1'b1;
  assign bp1_d  = (RAND_EN != 0) ? (random[BP1_HI:BP1_LO] != 3'd0) : 1'b1;

  // reads are held off while any write is outstanding (read-after-write hazard)
  assign io_enq_0_ready = bp0_q & (wr_cnt != DEPTH_W);
  assign io_enq_1_ready = bp1_q & ~(io_enq_1_bits_isa_fcsr_rs & (wr_cnt != 4'd0));

  assign fire0  = io_enq_0_valid & io_enq_0_ready;
  assign fire1  = io_enq_1_valid & io_enq_1_ready;
  assign inc    = fire0 & io_enq_0_bits_isa_fcsr_rw;
  assign rd_inc = fire1 & io_enq_1_bits_isa_fcsr_rs;
  assign hz_inc = io_enq_1_valid & io_enq_1_bits_isa_fcsr_rs & bp1_q & (wr_cnt != 4'd0);

  assign viol0 = stall0_q & (~io_enq_0_valid | (io_enq_0_bits_isa_fcsr_rw != held0_q));
  assign viol1 = stall1_q & (~io_enq_1_valid | (io_enq_1_bits_isa_fcsr_rs != held1_q));

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    dec     = 1'b0;
    case (state_q)
      IDLE: begin
        timer_d = reload;
        if (inc) state_d = DRAIN;
      end
      DRAIN: begin
        if (timer_q != 4'd0) begin
          timer_d = timer_q - 4'd1;
        end else begin
          dec     = 1'b1;
          timer_d = reload;
        end
      end
      default: state_d = IDLE;
    endcase
    wr_cnt_d = wr_cnt + 4'(inc) - 4'(dec);
    if (state_q == DRAIN && wr_cnt_d == 4'd0) state_d = IDLE;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q          <= IDLE;
      timer_q          <= 4'd0;
      wr_cnt           <= 4'd0;
      bp0_q            <= 1'b0;
      bp1_q            <= 1'b0;
      wr_acc_cnt       <= '0;
      rd_acc_cnt       <= '0;
      hazard_stall_cnt <= '0;
      stall0_q         <= 1'b0;
      stall1_q         <= 1'b0;
      held0_q          <= 1'b0;
      held1_q          <= 1'b0;
      proto_err        <= 1'b0;
      proto_err_code   <= 2'b00;
    end else begin
      state_q          <= state_d;
      timer_q          <= timer_d;
      wr_cnt           <= wr_cnt_d;
      bp0_q            <= bp0_d;
      bp1_q            <= bp1_d;
      wr_acc_cnt       <= wr_acc_cnt + CNT_W'(inc);
      rd_acc_cnt       <= rd_acc_cnt + CNT_W'(rd_inc);
      hazard_stall_cnt <= hazard_stall_cnt + CNT_W'(hz_inc);
      stall0_q         <= io_enq_0_valid & ~io_enq_0_ready;
      stall1_q         <= io_enq_1_valid & ~io_enq_1_ready;
      held0_q          <= io_enq_0_bits_isa_fcsr_rw;
      held1_q          <= io_enq_1_bits_isa_fcsr_rs;
      if (viol0) begin
        proto_err               <= 1'b1;
        proto_err_code[ERR_CH0] <= 1'b1;
      end
      if (viol1) begin
        proto_err               <= 1'b1;
        proto_err_code[ERR_CH1] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_random_csr_rsp.sv
// tb/tb_random_csr_rsp.sv - self-checking bench for random_csr_rsp
module tb_random_csr_rsp;

  localparam int LAT = 3;
  localparam int DEP = 4;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int n_chk = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // deterministic instance: fixed latency, no throttling
  logic        d_reset, d_v0, d_rw, d_v1, d_rs, d_r0, d_r1, d_err;
  logic [3:0]  d_cnt;
  logic [31:0] d_wacc, d_racc, d_hz;
  logic [1:0]  d_code;

  random_csr_rsp #(.DEPTH(DEP), .CNT_W(32), .RAND_EN(0), .FIX_LAT(4'(LAT))) u_det (
    .clock(clock), .reset(d_reset),
    .io_enq_0_valid(d_v0), .io_enq_0_bits_isa_fcsr_rw(d_rw), .io_enq_0_ready(d_r0),
    .io_enq_1_valid(d_v1), .io_enq_1_bits_isa_fcsr_rs(d_rs), .io_enq_1_ready(d_r1),
    .wr_cnt(d_cnt), .wr_acc_cnt(d_wacc), .rd_acc_cnt(d_racc), .hazard_stall_cnt(d_hz),
    .proto_err(d_err), .proto_err_code(d_code)
  );

  // randomized instance: lfsr backpressure
  logic        r_reset, r_v0, r_rw, r_v1, r_rs, r_r0, r_r1, r_err;
  logic [3:0]  r_cnt;
  logic [31:0] r_wacc, r_racc, r_hz;
  logic [1:0]  r_code;

  random_csr_rsp #(.DEPTH(DEP), .CNT_W(32), .RAND_EN(1), .FIX_LAT(4'd3)) u_rnd (
    .clock(clock), .reset(r_reset),
    .io_enq_0_valid(r_v0), .io_enq_0_bits_isa_fcsr_rw(r_rw), .io_enq_0_ready(r_r0),
    .io_enq_1_valid(r_v1), .io_enq_1_bits_isa_fcsr_rs(r_rs), .io_enq_1_ready(r_r1),
    .wr_cnt(r_cnt), .wr_acc_cnt(r_wacc), .rd_acc_cnt(r_racc), .hazard_stall_cnt(r_hz),
    .proto_err(r_err), .proto_err_code(r_code)
  );

  // reference model: outstanding count plus the cycle index of the next retire
  int    m_n, m_next, m_t;
  bit    m_bp, m_err;
  bit [1:0] m_code;
  int unsigned m_wacc, m_racc, m_hz;
  bit    m_st0, m_st1, m_h0, m_h1;
  bit    last_fire0, last_fire1, last_stall0, last_stall1;
  bit    rand_done = 1'b0;

  task automatic model_reset();
    m_n = 0; m_next = 0; m_t = 0; m_bp = 0; m_err = 0; m_code = 2'b00;
    m_wacc = 0; m_racc = 0; m_hz = 0;
    m_st0 = 0; m_st1 = 0; m_h0 = 0; m_h1 = 0;
    last_fire0 = 0; last_fire1 = 0; last_stall0 = 0; last_stall1 = 0;
  endtask

  task automatic do_reset();
    d_reset = 1'b1;
    d_v0 = 0; d_rw = 0; d_v1 = 0; d_rs = 0;
    repeat (2) @(negedge clock);
    #1;
    check("rst_ready0", d_r0, 0);
    check("rst_ready1", d_r1, 0);
    check("rst_wr_cnt", d_cnt, 0);
    check("rst_wr_acc", d_wacc, 0);
    check("rst_rd_acc", d_racc, 0);
    check("rst_hazard", d_hz, 0);
    check("rst_proto_err", d_err, 0);
    check("rst_proto_code", d_code, 0);
    d_reset = 1'b0;
    model_reset();
  endtask

  // one cycle: drive, compare every output against the model, advance the model
  task automatic step(input bit v0, input bit b0, input bit v1, input bit b1);
    bit r0, r1, inc, dec, f1;
    int n_old;
    d_v0 = v0; d_rw = b0; d_v1 = v1; d_rs = b1;
    #1;
    r0 = m_bp && (m_n != DEP);
    r1 = m_bp && !(b1 && m_n != 0);
    check("ready0", d_r0, r0);
    check("ready1", d_r1, r1);
    check("wr_cnt", d_cnt, m_n);
    check("wr_acc", d_wacc, m_wacc);
    check("rd_acc", d_racc, m_racc);
    check("hazard", d_hz, m_hz);
    check("proto_err", d_err, m_err);
    check("proto_code", d_code, m_code);
    inc = v0 && r0 && b0;
    f1 = v1 && r1;
    n_old = m_n;
    dec = (m_n > 0) && (m_t == m_next);
    if (v1 && b1 && m_bp && m_n != 0) m_hz++;
    if (f1 && b1) m_racc++;
    if (inc) m_wacc++;
    if (m_st0 && (!v0 || b0 != m_h0)) begin m_err = 1; m_code[0] = 1; end
    if (m_st1 && (!v1 || b1 != m_h1)) begin m_err = 1; m_code[1] = 1; end
    m_st0 = v0 && !r0; m_h0 = b0;
    m_st1 = v1 && !r1; m_h1 = b1;
    m_n = m_n + int'(inc) - int'(dec);
    if ((n_old == 0 && inc) || (dec && m_n > 0)) m_next = m_t + LAT + 1;
    m_bp = 1; m_t++;
    last_fire0 = v0 && r0; last_fire1 = f1;
    last_stall0 = v0 && !r0; last_stall1 = v1 && !r1;
    @(negedge clock);
  endtask

  initial begin : main
    int ones, peak, g;
    bit v0, b0, v1, b1;
    d_reset = 1'b1; d_v0 = 0; d_rw = 0; d_v1 = 0; d_rs = 0;
    @(negedge clock);

    // single write retires after LAT+1 cycles
    do_reset();
    step(0, 0, 0, 0);
    step(1, 1, 0, 0);
    ones = (d_cnt == 4'd1) ? 1 : 0;
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 0, 0);
      if (d_cnt == 4'd1) ones++;
    end
    check("t1_busy_cycles", ones, 4);
    check("t1_wr_acc", d_wacc, 1);

    // continuous writes fill to DEPTH
    peak = 0;
    for (int i = 0; i < 20; i++) begin
      step(1, 1, 0, 0);
      if (int'(d_cnt) > peak) peak = int'(d_cnt);
    end
    g = 0;
    while (!last_fire0 && g < 20) begin step(1, 1, 0, 0); g++; end
    check("t2_peak", peak, DEP);
    repeat (20) step(0, 0, 0, 0);
    check("t2_proto_err", d_err, 0);

    // read-after-write hazard stall
    do_reset();
    step(0, 0, 0, 0);
    step(1, 1, 0, 0);
    g = 0;
    do begin step(0, 0, 1, 1); g++; end while (!last_fire1 && g < 20);
    check("t3_hazard", d_hz, 4);
    check("t3_rd_acc", d_racc, 1);

    // rs=0 is accepted while writes are outstanding
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    check("t4_wr_cnt", d_cnt, 2);
    step(0, 0, 1, 0);
    check("t4_rs0_fire", last_fire1, 1);
    check("t4_rd_acc", d_racc, 1);
    repeat (20) step(0, 0, 0, 0);

    // random protocol-respecting traffic
    v0 = 0; b0 = 0; v1 = 0; b1 = 0;
    for (int i = 0; i < 400; i++) begin
      if (!last_stall0) begin v0 = ($urandom_range(0, 1) == 1); b0 = ($urandom_range(0, 3) != 0); end
      if (!last_stall1) begin v1 = ($urandom_range(0, 1) == 1); b1 = ($urandom_range(0, 1) == 1); end
      step(v0, b0, v1, b1);
    end

    // valid dropped while stalled on full
    do_reset();
    step(0, 0, 0, 0);
    g = 0;
    do begin step(1, 1, 0, 0); g++; end while (!last_stall0 && g < 30);
    check("t5_stalled", last_stall0, 1);
    step(0, 0, 0, 0);
    repeat (3) step(0, 0, 0, 0);
    check("t5_proto_err", d_err, 1);
    check("t5_proto_code", d_code, 2'b01);
    do_reset();

    for (int i = 0; i < 20000 && !rand_done; i++) @(negedge clock);
    check("rand_done", rand_done, 1);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin : rnd
    bit v0, b0, v1, b1, st0, st1;
    int unsigned e_wacc, e_racc;
    r_reset = 1'b1; r_v0 = 0; r_rw = 0; r_v1 = 0; r_rs = 0;
    repeat (3) @(negedge clock);
    r_reset = 1'b0;
    v0 = 0; b0 = 0; v1 = 0; b1 = 0; st0 = 0; st1 = 0;
    e_wacc = 0; e_racc = 0;
    for (int i = 0; i < 10000; i++) begin
      if (!st0) begin v0 = ($urandom_range(0, 2) != 0); b0 = ($urandom_range(0, 3) != 0); end
      if (!st1) begin v1 = ($urandom_range(0, 1) == 1); b1 = ($urandom_range(0, 2) != 0); end
      r_v0 = v0; r_rw = b0; r_v1 = v1; r_rs = b1;
      #1;
      check("r_wr_cnt_max", (r_cnt > 4'(DEP)), 0);
      check("r_full_ready0", (r_r0 && r_cnt == 4'(DEP)), 0);
      check("r_rs_fire_hazard", (v1 && b1 && r_r1 && r_cnt != 4'd0), 0);
      if (v0 && r_r0 && b0) e_wacc++;
      if (v1 && r_r1 && b1) e_racc++;
      st0 = v0 && !r_r0;
      st1 = v1 && !r_r1;
      @(negedge clock);
    end
    r_v0 = 0; r_v1 = 0;
    #1;
    check("r_wr_acc", r_wacc, e_wacc);
    check("r_rd_acc", r_racc, e_racc);
    check("r_proto_err", r_err, 0);
    check("r_proto_code", r_code, 0);
    rand_done = 1'b1;
  end

endmodule
